multicycle_ctrl_fsm: RTL and testbench

- Main sequencing FSM for the multicycle variant of the 32-bit ARM core.
- Replaces the single-cycle main decoder's combinational control word with a per-state control word.
- Steps the shared ALU, the register file and one unified instruction/data memory port through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Sits inside the controller, beside the existing ALU decoder and condition logic:
  - The ALU decoder consumes `alu_op`.
  - The condition logic gates `reg_w`, `mem_w` and `branch` with CondEx.

---
 rtl/arm_mc_pkg.sv | 24 ++
 rtl/multicycle_ctrl_fsm.sv | 105 ++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 134 +++++++++++++
 3 files changed

// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: state encoding and datapath mux select codes for the multicycle ARM core
package arm_mc_pkg;
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;
    localparam logic [1:0] SRCA_REG      = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT   = 2'b10;
    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main sequencing FSM producing the per-state control word
module multicycle_ctrl_fsm
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       adr_src,
    output logic       ir_write,
    output logic       next_pc,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic [3:0] state
);
    state_t state_q, state_d;
    logic   funct_unused;

    assign funct_unused = ^funct[4:1];
    assign state        = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        alu_op     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_rdy;
                next_pc    = mem_rdy;
                state_d    = mem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_d    = (op == 2'b01) ? MEMADR :
                             (op == 2'b00) ? (funct[5] ? EXECI : EXECR) :
                             (op == 2'b10) ? BRANCH : FETCH;
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                state_d = mem_rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            MEMWR: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_w   = 1'b1;
                state_d = mem_rdy ? FETCH : MEMWR;
            end
            EXECR: begin
                alu_op  = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: reg_w = 1'b1;
            BRANCH: begin
                alu_src_a  = SRCA_ALUOUT;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // reset may land mid-cycle; kill every side-effecting enable at once
        if (reset) {mem_req, ir_write, next_pc, reg_w, mem_w, branch} = 6'b0;
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl_fsm;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_rdy;
    logic       mem_req, adr_src, ir_write, next_pc, alu_op, reg_w, mem_w, branch;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] state;
    logic [13:0] obs;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [13:0] ctl;
    } exp_t;
    exp_t sb[$];

    localparam logic [13:0] RST_W = {4'b0000, 2'b01, 2'b10, 2'b10, 4'b0000};

    multicycle_ctrl_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .next_pc(next_pc),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_op(alu_op), .reg_w(reg_w), .mem_w(mem_w), .branch(branch), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, adr_src, ir_write, next_pc, alu_src_a, alu_src_b,
                  result_src, alu_op, reg_w, mem_w, branch};

    // control word per state: {mem_req,adr_src,ir_write,next_pc,a,b,res,alu_op,reg_w,mem_w,branch}
    function automatic logic [13:0] model(input logic [3:0] s, input logic r);
        case (s)
            4'd0: model = {1'b1, 1'b0, r, r, 2'b01, 2'b10, 2'b10, 4'b0000};
            4'd1: model = {4'b0000, 2'b01, 2'b10, 2'b10, 4'b0000};
            4'd2: model = {4'b0000, 2'b00, 2'b01, 2'b00, 4'b0000};
            4'd3: model = {4'b1100, 6'b000000, 4'b0000};
            4'd4: model = {4'b0000, 2'b00, 2'b00, 2'b01, 4'b0100};
            4'd5: model = {4'b1100, 6'b000000, 4'b0010};
            4'd6: model = {4'b0000, 6'b000000, 4'b1000};
            4'd7: model = {4'b0000, 2'b00, 2'b01, 2'b00, 4'b1000};
            4'd8: model = {4'b0000, 6'b000000, 4'b0100};
            4'd9: model = {4'b0000, 2'b10, 2'b01, 2'b10, 4'b0001};
            default: model = 14'h0;
        endcase
    endfunction

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (state === e.st) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", e.tag, state, e.st);
        end
        checks++;
        assert (obs === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl: observed %b expected %b", e.tag, obs, e.ctl);
        end
    endtask

    task automatic cyc(input string tag, input logic [1:0] o, input logic [5:0] f,
                       input logic r, input logic [3:0] es);
        @(negedge clk);
        op = o;
        funct = f;
        mem_rdy = r;
        sb.push_back('{tag, es, model(es, r)});
        #1 check_out();
    endtask

    initial begin
        reset = 1'b1;
        op = 2'b00;
        funct = 6'b0;
        mem_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb.push_back('{"reset", 4'd0, RST_W});
        #1 check_out();
        @(posedge clk);
        #2 reset = 1'b0;
        // ADD register
        cyc("add_f",  2'b00, 6'b001000, 1'b1, 4'd0);
        cyc("add_d",  2'b00, 6'b001000, 1'b1, 4'd1);
        cyc("add_ex", 2'b00, 6'b001000, 1'b1, 4'd6);
        cyc("add_wb", 2'b00, 6'b001000, 1'b1, 4'd8);
        // LDR with two wait cycles; op/funct scrambled where they must be ignored
        cyc("ldr_f",  2'b01, 6'b011001, 1'b1, 4'd0);
        cyc("ldr_d",  2'b01, 6'b011001, 1'b1, 4'd1);
        cyc("ldr_ma", 2'b01, 6'b011001, 1'b1, 4'd2);
        cyc("ldr_w1", 2'b11, 6'b000000, 1'b0, 4'd3);
        cyc("ldr_w2", 2'b10, 6'b111110, 1'b0, 4'd3);
        cyc("ldr_rd", 2'b00, 6'b000000, 1'b1, 4'd3);
        cyc("ldr_wb", 2'b11, 6'b111111, 1'b1, 4'd4);
        // STR
        cyc("str_f",  2'b01, 6'b011000, 1'b1, 4'd0);
        cyc("str_d",  2'b01, 6'b011000, 1'b1, 4'd1);
        cyc("str_ma", 2'b01, 6'b011000, 1'b1, 4'd2);
        cyc("str_wr", 2'b01, 6'b011000, 1'b1, 4'd5);
        // B, then undefined op=11 with a stray mem_rdy=0 in DECODE
        cyc("b_f",    2'b10, 6'b000000, 1'b1, 4'd0);
        cyc("b_d",    2'b10, 6'b000000, 1'b1, 4'd1);
        cyc("b_br",   2'b10, 6'b000000, 1'b1, 4'd9);
        cyc("nop_f",  2'b11, 6'b000000, 1'b1, 4'd0);
        cyc("nop_d",  2'b11, 6'b000000, 1'b0, 4'd1);
        // fetch wait of three cycles, then EXECI aborted by reset
        cyc("fw_1",   2'b00, 6'b100000, 1'b0, 4'd0);
        cyc("fw_2",   2'b00, 6'b100000, 1'b0, 4'd0);
        cyc("fw_3",   2'b00, 6'b100000, 1'b0, 4'd0);
        cyc("fw_rdy", 2'b00, 6'b100000, 1'b1, 4'd0);
        cyc("ei_d",   2'b00, 6'b100000, 1'b1, 4'd1);
        cyc("ei_ex",  2'b00, 6'b100000, 1'b1, 4'd7);
        #2 reset = 1'b1;
        sb.push_back('{"rst_async", 4'd0, RST_W});
        #1 check_out();
        @(negedge clk);
        sb.push_back('{"rst_hold", 4'd0, RST_W});
        #1 check_out();
        @(posedge clk);
        #2 reset = 1'b0;
        cyc("post_f", 2'b00, 6'b000000, 1'b1, 4'd0);
        cyc("post_d", 2'b11, 6'b000000, 1'b1, 4'd1);
        cyc("post_f2",2'b11, 6'b000000, 1'b1, 4'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
